// File: rtl/cve_result_checker.sv
// On-chip scoreboard for the arithmetic DUT wrapper. It computes each vector's expected
// result, delays it to line up with the DUT output, and keeps run statistics.
module cve_result_checker #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  cfg_mode,
    input  logic [$clog2(MAX_DELAY):0]  cfg_delay,
    input  logic [15:0]                 num_vectors,
    input  logic                        vec_valid,
    input  logic [WIDTH-1:0]            vec_a,
    input  logic [WIDTH-1:0]            vec_b,
    input  logic [2*WIDTH-1:0]          dut_result,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 test_count,
    output logic [15:0]                 pass_count,
    output logic [15:0]                 fail_count,
    output logic                        first_fail_valid,
    output logic [WIDTH-1:0]            first_fail_a,
    output logic [WIDTH-1:0]            first_fail_b,
    output logic [2*WIDTH-1:0]          first_fail_result,
    output logic [2*WIDTH-1:0]          first_fail_expected
);
    localparam int DW = $clog2(MAX_DELAY) + 1;
    localparam int RW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [RW-1:0] expected_of(input logic [1:0] mode,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] sum;
        sum = a + b;
        case (mode)
            2'd0, 2'd1: expected_of = {{WIDTH{1'b0}}, sum};
            2'd2:       expected_of = RW'(a) * RW'(b);
            default:    expected_of = '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
        if (d == '0) return DW'(1);
        if (d > DW'(MAX_DELAY)) return DW'(MAX_DELAY);
        return d;
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           mode_q;
    logic [DW-1:0]        delay_q;
    logic [15:0]          num_q;
    logic [15:0]          accepted_q;
    logic [MAX_DELAY-1:0] pipe_vld;
    logic [WIDTH-1:0]     pipe_a   [MAX_DELAY];
    logic [WIDTH-1:0]     pipe_b   [MAX_DELAY];
    logic [RW-1:0]        pipe_exp [MAX_DELAY];

    logic             start_run, accept, pending, compare, match;
    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic [RW-1:0]    cmp_exp;

    assign start_run = start && (state_q != RUN);
    assign accept    = (state_q == RUN) && vec_valid && (accepted_q < num_q);
    assign compare   = (state_q == RUN) && cmp_vld;
    assign match     = (dut_result == cmp_exp);

    // Only stages ahead of the compare tap hold work still owed; entries past it are spent.
    always_comb begin
        cmp_vld = 1'b0;
        cmp_a   = '0;
        cmp_b   = '0;
        cmp_exp = '0;
        pending = 1'b0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (i < int'(delay_q)) pending = pending | pipe_vld[i];
            if (i + 1 == int'(delay_q)) begin
                cmp_vld = pipe_vld[i];
                cmp_a   = pipe_a[i];
                cmp_b   = pipe_b[i];
                cmp_exp = pipe_exp[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q == RUN);
        done    = (state_q == DONE);
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if ((accepted_q == num_q) && !pending) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            mode_q              <= '0;
            delay_q             <= '0;
            num_q               <= '0;
            accepted_q          <= '0;
            pipe_vld            <= '0;
            test_count          <= '0;
            pass_count          <= '0;
            fail_count          <= '0;
            first_fail_valid    <= 1'b0;
            first_fail_a        <= '0;
            first_fail_b        <= '0;
            first_fail_result   <= '0;
            first_fail_expected <= '0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                mode_q              <= cfg_mode;
                delay_q             <= clamp_delay(cfg_delay);
                num_q               <= num_vectors;
                accepted_q          <= '0;
                pipe_vld            <= '0;
                test_count          <= '0;
                pass_count          <= '0;
                fail_count          <= '0;
                first_fail_valid    <= 1'b0;
                first_fail_a        <= '0;
                first_fail_b        <= '0;
                first_fail_result   <= '0;
                first_fail_expected <= '0;
            end else if (state_q == RUN) begin
                pipe_vld <= (pipe_vld << 1) | MAX_DELAY'(accept);
                if (accept) accepted_q <= accepted_q + 16'd1;
                if (compare) begin
                    test_count <= sat_inc(test_count);
                    if (match) begin
                        pass_count <= sat_inc(pass_count);
                    end else begin
                        fail_count <= sat_inc(fail_count);
                        if (!first_fail_valid) begin
                            first_fail_valid    <= 1'b1;
                            first_fail_a        <= cmp_a;
                            first_fail_b        <= cmp_b;
                            first_fail_result   <= dut_result;
                            first_fail_expected <= cmp_exp;
                        end
                    end
                end
            end
        end
    end

    // Operand/expectation payload needs no reset: it is only read where pipe_vld is set.
    always_ff @(posedge clk) begin
        if (state_q == RUN) begin
            pipe_a[0]   <= vec_a;
            pipe_b[0]   <= vec_b;
            pipe_exp[0] <= expected_of(mode_q, vec_a, vec_b);
            for (int i = 1; i < MAX_DELAY; i++) begin
                pipe_a[i]   <= pipe_a[i-1];
                pipe_b[i]   <= pipe_b[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cve_result_checker.sv
// Bench for cve_result_checker: directed and randomized runs compared every cycle against
// a queue-based scoreboard model of vectors awaiting their compare time.
module tb_cve_result_checker;
    localparam int W    = 8;
    localparam int MAXD = 8;
    localparam int DW   = $clog2(MAXD) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic vec_valid = 1'b0;
    logic [1:0]     cfg_mode = '0;
    logic [DW-1:0]  cfg_delay = '0;
    logic [15:0]    num_vectors = '0;
    logic [W-1:0]   vec_a = '0, vec_b = '0;
    logic [2*W-1:0] dut_result = '0;
    logic busy, done, first_fail_valid;
    logic [15:0] test_count, pass_count, fail_count;
    logic [W-1:0] first_fail_a, first_fail_b;
    logic [2*W-1:0] first_fail_result, first_fail_expected;

    int total = 0;
    int bad = 0;

    cve_result_checker #(.WIDTH(W), .MAX_DELAY(MAXD)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
        .cfg_delay(cfg_delay), .num_vectors(num_vectors), .vec_valid(vec_valid),
        .vec_a(vec_a), .vec_b(vec_b), .dut_result(dut_result), .busy(busy), .done(done),
        .test_count(test_count), .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_valid(first_fail_valid), .first_fail_a(first_fail_a),
        .first_fail_b(first_fail_b), .first_fail_result(first_fail_result),
        .first_fail_expected(first_fail_expected)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp;
        int drv;
        int due;
    } ent_t;

    ent_t pq[$];
    int q_a[$], q_b[$], q_r[$];
    int m_run, m_done, m_test, m_pass, m_fail, m_ffv, m_ffa, m_ffb, m_ffr, m_ffe;
    int m_acc, m_nvec, m_mode, m_d, cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_exp(input int mode, input int a, input int b);
        case (mode)
            0, 1:    return (a + b) % (1 << W);
            2:       return a * b;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_clear();
        m_test = 0; m_pass = 0; m_fail = 0;
        m_ffv = 0; m_ffa = 0; m_ffb = 0; m_ffr = 0; m_ffe = 0;
        m_acc = 0;
        pq.delete();
    endtask

    task automatic check_state();
        check_val("busy", busy, m_run);
        check_val("done", done, m_done);
        check_val("test_count", test_count, m_test);
        check_val("pass_count", pass_count, m_pass);
        check_val("fail_count", fail_count, m_fail);
        check_val("ff_valid", first_fail_valid, m_ffv);
    endtask

    task automatic check_ff();
        check_val("ff_a", first_fail_a, m_ffa);
        check_val("ff_b", first_fail_b, m_ffb);
        check_val("ff_result", first_fail_result, m_ffr);
        check_val("ff_expected", first_fail_expected, m_ffe);
    endtask

    task automatic start_run(input int mode, input int dly, input int nvec);
        @(negedge clk);
        start = 1'b1;
        vec_valid = 1'b0;
        cfg_mode = 2'(mode);
        cfg_delay = DW'(dly);
        num_vectors = 16'(nvec);
        @(posedge clk);
        model_clear();
        m_run = 1; m_done = 0;
        m_nvec = nvec; m_mode = mode;
        m_d = (dly == 0) ? 1 : (dly > MAXD) ? MAXD : dly;
        cyc = 1;
    endtask

    task automatic run_body(input int pulses, input int err_pct, input bit dense);
        int left;
        int guard;
        int a, b, r;
        bit done_now;
        ent_t ec, en;
        left = pulses;
        guard = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            check_state();
            if (!(left > 0 || m_run != 0)) break;
            guard++;
            if (guard > 3000) begin
                total++; bad++;
                $display("FAIL timeout: busy %0d done %0d after %0d cycles", busy, done, guard);
                break;
            end
            vec_valid = (left > 0) && (dense || $urandom_range(0, 3) != 0);
            r = -1;
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            if (vec_valid) begin
                left--;
                if (q_a.size() > 0) begin
                    a = q_a.pop_front();
                    b = q_b.pop_front();
                    r = q_r.pop_front();
                end
            end
            vec_a = W'(a);
            vec_b = W'(b);
            done_now = (m_run != 0) && (m_acc == m_nvec) && (pq.size() == 0);
            if (m_run != 0 && pq.size() > 0 && pq[0].due == cyc) begin
                ec = pq.pop_front();
                dut_result = 16'(ec.drv);
                m_test = sat(m_test);
                if (ec.drv == ec.exp) m_pass = sat(m_pass);
                else begin
                    m_fail = sat(m_fail);
                    if (m_ffv == 0) begin
                        m_ffv = 1; m_ffa = ec.a; m_ffb = ec.b; m_ffr = ec.drv; m_ffe = ec.exp;
                    end
                end
            end else begin
                dut_result = 16'($urandom);
            end
            if (m_run != 0 && vec_valid && m_acc < m_nvec) begin
                en.a = a;
                en.b = b;
                en.exp = ref_exp(m_mode, a, b);
                if (r >= 0) en.drv = r;
                else if (int'($urandom_range(0, 99)) < err_pct)
                    en.drv = en.exp ^ (1 << $urandom_range(0, 15));
                else en.drv = en.exp;
                en.due = cyc + m_d;
                pq.push_back(en);
                m_acc++;
            end
            if (done_now) begin
                m_run = 0;
                m_done = 1;
            end
            @(posedge clk);
            cyc++;
        end
        vec_valid = 1'b0;
        check_ff();
    endtask

    initial begin
        m_run = 0; m_done = 0;
        model_clear();
        repeat (3) @(negedge clk);
        check_state();
        check_ff();
        reset = 1'b1;

        // Mode 1, D=2: directed pairs, all results correct (carry-out pairs expect 0)
        q_a = '{5, 10, 15, 0, 255, 128, 1, 127};
        q_b = '{3, 4, 2, 100, 1, 128, 255, 129};
        q_r = '{8, 14, 17, 100, 0, 0, 0, 0};
        start_run(1, 2, 8);
        run_body(8, 0, 1'b1);
        check_val("t1_test", test_count, 8);
        check_val("t1_pass", pass_count, 8);
        check_val("t1_fail", fail_count, 0);
        check_val("t1_done", done, 1);

        // Mode 2, D=3: one pass then one mismatch
        q_a = '{255, 16};
        q_b = '{255, 16};
        q_r = '{65025, 255};
        start_run(2, 3, 2);
        run_body(2, 0, 1'b1);
        check_val("t2_pass", pass_count, 1);
        check_val("t2_fail", fail_count, 1);
        check_val("t2_ff_a", first_fail_a, 16);
        check_val("t2_ff_b", first_fail_b, 16);
        check_val("t2_ff_res", first_fail_result, 255);
        check_val("t2_ff_exp", first_fail_expected, 256);

        // Mode 0, D=1: three consecutive mismatches
        q_a = '{1, 3, 5};
        q_b = '{2, 4, 6};
        q_r = '{0, 1, 2};
        start_run(0, 1, 3);
        run_body(3, 0, 1'b1);
        check_val("t3_fail", fail_count, 3);
        check_val("t3_ff_a", first_fail_a, 1);
        check_val("t3_ff_res", first_fail_result, 0);
        check_val("t3_ff_exp", first_fail_expected, 3);

        // Six pulses against num_vectors=4
        start_run(2, 5, 4);
        run_body(6, 0, 1'b1);
        check_val("t4_test", test_count, 4);
        check_val("t4_done", done, 1);

        // Reset mid-run: two compares done, three vectors still in flight
        start_run(2, 4, 10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            vec_valid = (i < 5);
            vec_a = 8'd3;
            vec_b = 8'd5;
            dut_result = '0;
            @(posedge clk);
        end
        vec_valid = 1'b0;
        @(negedge clk);
        check_val("rst_pre_fail", fail_count, 2);
        check_val("rst_pre_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        m_run = 0; m_done = 0;
        model_clear();
        check_state();
        check_ff();
        @(negedge clk);
        reset = 1'b1;
        vec_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_state();
        vec_valid = 1'b0;
        start_run(2, 4, 10);
        run_body(10, 25, 1'b0);

        // Delay clamping extremes
        start_run(0, 0, 6);
        run_body(7, 30, 1'b0);
        start_run(2, 15, 6);
        run_body(6, 30, 1'b1);

        // Randomized runs
        for (int k = 0; k < 12; k++) begin
            int md, dl, nv;
            md = int'($urandom_range(0, 3));
            dl = int'($urandom_range(0, 15));
            nv = int'($urandom_range(1, 20));
            start_run(md, dl, nv);
            run_body(nv + int'($urandom_range(0, 3)), 20, k[0]);
        end

        // Empty run restarted from DONE: statistics cleared, done one cycle after start
        start_run(1, 3, 0);
        run_body(0, 0, 1'b1);
        check_val("t6_test", test_count, 0);
        check_val("t6_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
